// File: rtl/sram_ctrl_ws.sv
// Asynchronous-SRAM controller: one 1/2/4-byte user access becomes 1..4 SRAM beats,
// each a SETUP / STROBE / HOLD sequence with a programmable strobe stretch.
module sram_ctrl_ws #(
  parameter int VA_WIDTH    = 19,
  parameter int PHY_DW      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [VA_WIDTH-1:0]                   addr,
  input  logic                                  w_rb,
  input  logic [1:0]                            acc,
  input  logic [31:0]                           wdata,
  input  logic                                  req,
  output logic                                  ready,
  output logic [31:0]                           rdata,
  output logic                                  resp,
  output logic                                  fault,
  output logic [VA_WIDTH-$clog2(PHY_DW/8)-1:0]  sram_addr,
  output logic                                  sram_ce_bar,
  output logic                                  sram_oe_bar,
  output logic                                  sram_we_bar,
  output logic [PHY_DW/8-1:0]                   sram_be_bar,
  output logic                                  sram_data_dir,
  output logic [PHY_DW-1:0]                     sram_data_out,
  input  logic [PHY_DW-1:0]                     sram_data_in
);
  localparam int NB  = PHY_DW / 8;
  localparam int SH  = $clog2(NB);
  localparam int SAW = VA_WIDTH - SH;
  localparam logic IOR_DIR_OUT = 1'b1;
  localparam logic IOR_DIR_IN  = 1'b0;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [1:0]          beat_q, beat_d;
  logic [VA_WIDTH-1:0] addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [1:0]          acc_q, acc_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rbuf_q, rbuf_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                invalid, accept, busy, single, last_strobe;
  logic [1:0]          last_beat;

  // byte of the 32-bit user word carried by lane j of the current beat
  function automatic logic [1:0] bidx(input logic [1:0] beat, input int j);
    bidx = 2'(int'(beat) * NB + j);
  endfunction

  assign invalid = (acc == 2'd3) | ((acc == 2'd1) & addr[0]) | ((acc == 2'd2) & (addr[1:0] != 2'b00));
  assign ready   = (state_q == IDLE);
  assign fault   = req & ready & invalid;
  assign accept  = req & ready & ~invalid;
  assign busy    = (state_q == SETUP) | (state_q == STROBE) | (state_q == HOLD);
  assign single  = (acc_q == 2'd0);
  assign last_strobe = (state_q == STROBE) && (cnt_q == 3'(WAIT_CYCLES));

  always_comb begin
    if (NB == 1) last_beat = (acc_q == 2'd2) ? 2'd3 : acc_q;
    else         last_beat = (acc_q == 2'd2) ? 2'd1 : 2'd0;
  end

  always_comb begin
    sram_data_out = '0;
    sram_be_bar   = '1;
    for (int j = 0; j < NB; j++) begin
      sram_data_out[8*j +: 8] = single ? wdata_q[7:0] : wdata_q[8*bidx(beat_q, j) +: 8];
      // a single byte on a wide bus only drives the lane picked by addr[0]
      sram_be_bar[j] = ~busy | (single && NB == 2 && (addr_q[0] != 1'(j)));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    acc_d   = acc_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d  = addr;
        wr_d    = w_rb;
        acc_d   = acc;
        wdata_d = wdata;
        rbuf_d  = '0;
        cnt_d   = '0;
        beat_d  = '0;
        state_d = SETUP;
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = STROBE;
      end
      STROBE: begin
        if (last_strobe) begin
          state_d = HOLD;
          if (!wr_q) begin
            for (int j = 0; j < NB; j++) begin
              if (!single)                           rbuf_d[8*bidx(beat_q, j) +: 8] = sram_data_in[8*j +: 8];
              else if (NB == 1 || addr_q[0] == 1'(j)) rbuf_d[7:0] = sram_data_in[8*j +: 8];
            end
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HOLD: begin
        if (beat_q == last_beat) begin
          state_d = DONE;
          if (!wr_q) rdata_d = rbuf_q;
        end else begin
          beat_d  = beat_q + 2'd1;
          state_d = SETUP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      acc_q   <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      acc_q   <= acc_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
    end
  end

  assign resp          = (state_q == DONE);
  assign rdata         = rdata_q;
  assign sram_addr     = addr_q[VA_WIDTH-1:SH] + SAW'(beat_q);
  assign sram_we_bar   = ~(rstn & wr_q & (state_q == STROBE));
  assign sram_data_dir = (busy & wr_q) ? IOR_DIR_OUT : IOR_DIR_IN;
  assign sram_ce_bar   = ~rstn;
  assign sram_oe_bar   = ~rstn;
endmodule

// File: tb/tb_sram_ctrl_ws.sv
// Bench for sram_ctrl_ws: three controller configurations, each with a behavioural SRAM,
// driven from a vector table with a scoreboard plus hand-written fault/abort sequences.
module tb_sram_ctrl_ws;
  logic clk = 1'b0, rstn = 1'b0, load = 1'b1, mon_clr = 1'b1;
  always #5 clk = ~clk;

  logic [18:0] addr[3];
  logic        w_rb[3], req[3];
  logic [1:0]  acc[3];
  logic [31:0] wdata[3], rdata[3];
  logic        ready[3], resp[3], fault[3];
  logic        ce_b[3], oe_b[3], we_b[3], dir[3];
  logic [18:0] sa0, sa1;
  logic [17:0] sa2;
  logic [0:0]  be0, be1;
  logic [1:0]  be2, be_seen;
  logic [7:0]  sdo0, sdo1, sdi0, sdi1;
  logic [15:0] sdo2, sdi2;
  logic [7:0]  mem0[256], mem1[256];
  logic [15:0] mem2[128];

  sram_ctrl_ws #(.VA_WIDTH(19), .PHY_DW(8), .WAIT_CYCLES(1)) u0 (
    .clk(clk), .rstn(rstn), .addr(addr[0]), .w_rb(w_rb[0]), .acc(acc[0]), .wdata(wdata[0]),
    .req(req[0]), .ready(ready[0]), .rdata(rdata[0]), .resp(resp[0]), .fault(fault[0]),
    .sram_addr(sa0), .sram_ce_bar(ce_b[0]), .sram_oe_bar(oe_b[0]), .sram_we_bar(we_b[0]),
    .sram_be_bar(be0), .sram_data_dir(dir[0]), .sram_data_out(sdo0), .sram_data_in(sdi0));
  sram_ctrl_ws #(.VA_WIDTH(19), .PHY_DW(8), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rstn(rstn), .addr(addr[1]), .w_rb(w_rb[1]), .acc(acc[1]), .wdata(wdata[1]),
    .req(req[1]), .ready(ready[1]), .rdata(rdata[1]), .resp(resp[1]), .fault(fault[1]),
    .sram_addr(sa1), .sram_ce_bar(ce_b[1]), .sram_oe_bar(oe_b[1]), .sram_we_bar(we_b[1]),
    .sram_be_bar(be1), .sram_data_dir(dir[1]), .sram_data_out(sdo1), .sram_data_in(sdi1));
  sram_ctrl_ws #(.VA_WIDTH(19), .PHY_DW(16), .WAIT_CYCLES(1)) u2 (
    .clk(clk), .rstn(rstn), .addr(addr[2]), .w_rb(w_rb[2]), .acc(acc[2]), .wdata(wdata[2]),
    .req(req[2]), .ready(ready[2]), .rdata(rdata[2]), .resp(resp[2]), .fault(fault[2]),
    .sram_addr(sa2), .sram_ce_bar(ce_b[2]), .sram_oe_bar(oe_b[2]), .sram_we_bar(we_b[2]),
    .sram_be_bar(be2), .sram_data_dir(dir[2]), .sram_data_out(sdo2), .sram_data_in(sdi2));

  // behavioural SRAMs: asynchronous read, write sampled on each clock edge while WE is low
  assign sdi0 = mem0[sa0[7:0]];
  assign sdi1 = mem1[sa1[7:0]];
  assign sdi2 = mem2[sa2[6:0]];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) begin mem0[i] <= 8'h00; mem1[i] <= 8'h00; end
      for (int i = 0; i < 128; i++) mem2[i] <= 16'h0000;
      mem0[16] <= 8'h11; mem0[17] <= 8'h22; mem0[18] <= 8'h33; mem0[19] <= 8'h44;
      mem2[2]  <= 16'hAB12; mem2[3] <= 16'h3456; mem2[4] <= 16'h0077;
    end else begin
      if (!we_b[0]) mem0[sa0[7:0]] <= sdo0;
      if (!we_b[1]) mem1[sa1[7:0]] <= sdo1;
      if (!we_b[2]) begin
        if (!be2[0]) mem2[sa2[6:0]][7:0]  <= sdo2[7:0];
        if (!be2[1]) mem2[sa2[6:0]][15:8] <= sdo2[15:8];
      end
    end
  end

  int   we_low1, we_pulse1;
  logic we_prev1;
  always @(posedge clk) begin
    if (mon_clr) begin
      we_low1 <= 0; we_pulse1 <= 0; we_prev1 <= 1'b1;
    end else begin
      if (!we_b[1]) begin
        we_low1 <= we_low1 + 1;
        if (we_prev1) we_pulse1 <= we_pulse1 + 1;
      end
      we_prev1 <= we_b[1];
    end
  end

  typedef struct { int u; logic [18:0] a; logic w; logic [1:0] acc; logic [31:0] wd; logic [31:0] rd; int lat; } vec_t;
  typedef struct { logic [31:0] rd; int lat; } exp_t;
  vec_t        tv[12];
  exp_t        sb[$];
  logic [31:0] last_rd[3];
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic run_vec(input vec_t v);
    int n; logic got; exp_t e; logic [31:0] er;
    er = v.w ? last_rd[v.u] : v.rd;
    if (!v.w) last_rd[v.u] = v.rd;
    addr[v.u] = v.a; w_rb[v.u] = v.w; acc[v.u] = v.acc; wdata[v.u] = v.wd; req[v.u] = 1'b1;
    sb.push_back('{rd: er, lat: v.lat});
    #1 chk("fault_legal", fault[v.u], 0);
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); #1; n++;
      req[v.u] = 1'b0;
      if (v.u == 2 && n == 2) be_seen = be2;
      got = resp[v.u];
    end
    e = sb.pop_front();
    chk("resp_seen", 32'(got), 1);
    if (got) begin
      chk("latency", n, e.lat);
      chk("rdata", rdata[v.u], e.rd);
      chk("ready_in_done", ready[v.u], 0);
      @(posedge clk); #1;
      chk("resp_one_cycle", resp[v.u], 0);
      chk("ready_back", ready[v.u], 1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int rc;
    tv[0]  = '{u:0, a:19'h10, w:1'b0, acc:2'd2, wd:32'h0,        rd:32'h44332211, lat:17};
    tv[1]  = '{u:1, a:19'h06, w:1'b1, acc:2'd1, wd:32'h0000BEEF, rd:32'h0,        lat:7};
    tv[2]  = '{u:1, a:19'h06, w:1'b0, acc:2'd1, wd:32'h0,        rd:32'h0000BEEF, lat:7};
    tv[3]  = '{u:2, a:19'h05, w:1'b0, acc:2'd0, wd:32'h0,        rd:32'h000000AB, lat:5};
    tv[4]  = '{u:0, a:19'h12, w:1'b0, acc:2'd0, wd:32'h0,        rd:32'h00000033, lat:5};
    tv[5]  = '{u:0, a:19'h20, w:1'b1, acc:2'd2, wd:32'hCAFEF00D, rd:32'h0,        lat:17};
    tv[6]  = '{u:0, a:19'h20, w:1'b0, acc:2'd2, wd:32'h0,        rd:32'hCAFEF00D, lat:17};
    tv[7]  = '{u:2, a:19'h09, w:1'b1, acc:2'd0, wd:32'h0000005A, rd:32'h0,        lat:5};
    tv[8]  = '{u:2, a:19'h08, w:1'b0, acc:2'd1, wd:32'h0,        rd:32'h00005A77, lat:5};
    tv[9]  = '{u:2, a:19'h04, w:1'b0, acc:2'd2, wd:32'h0,        rd:32'h3456AB12, lat:9};
    tv[10] = '{u:0, a:19'h12, w:1'b0, acc:2'd1, wd:32'h0,        rd:32'h00004433, lat:9};
    tv[11] = '{u:0, a:19'h10, w:1'b0, acc:2'd0, wd:32'h0,        rd:32'h00000011, lat:5};
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; w_rb[i] = 1'b0; acc[i] = '0; wdata[i] = '0; req[i] = 1'b0; last_rd[i] = '0;
    end
    be_seen = '1;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ce_high", ce_b[i], 1);
      chk("rst_oe_high", oe_b[i], 1);
    end
    chk("rst_we_high", we_b[0], 1);
    chk("rst_dir_in", dir[0], 0);
    chk("rst_resp_low", resp[0], 0);
    chk("rst_rdata_zero", rdata[0], 0);
    rstn = 1'b1; load = 1'b0; mon_clr = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", ready[0], 1);
    chk("ce_active", ce_b[0], 0);
    chk("oe_active", oe_b[0], 0);

    for (int i = 0; i < 11; i++) begin
      run_vec(tv[i]);
      if (i == 1) begin
        chk("wr_byte_lo", mem1[6], 8'hEF);
        chk("wr_byte_hi", mem1[7], 8'hBE);
        chk("we_pulses", we_pulse1, 2);
        chk("we_low_cycles", we_low1, 2);
      end
      if (i == 3) chk("be_single_hi_lane", be_seen, 2'b01);
      if (i == 7) chk("wr16_lane_hi", mem2[4], 16'h5A77);
    end

    // illegal requests: immediate fault, nothing accepted, SRAM stays quiet
    addr[0] = 19'h2; acc[0] = 2'd2; w_rb[0] = 1'b0; req[0] = 1'b1;
    #1 chk("fault_misaligned_4b", fault[0], 1);
    @(posedge clk); #1;
    chk("misal_not_accepted", ready[0], 1);
    chk("misal_dir_in", dir[0], 0);
    addr[0] = 19'h0; acc[0] = 2'd3; w_rb[0] = 1'b1;
    #1 chk("fault_acc3", fault[0], 1);
    @(posedge clk); #1;
    chk("acc3_not_accepted", ready[0], 1);
    chk("acc3_we_high", we_b[0], 1);
    chk("acc3_dir_in", dir[0], 0);
    addr[0] = 19'h1; acc[0] = 2'd1;
    #1 chk("fault_misaligned_2b", fault[0], 1);
    req[0] = 1'b0;
    #1 chk("fault_needs_req", fault[0], 0);

    // write in flight, ignored requests while busy, then reset mid-STROBE
    @(posedge clk); #1;
    addr[0] = 19'h30; w_rb[0] = 1'b1; acc[0] = 2'd2; wdata[0] = 32'h12345678; req[0] = 1'b1;
    @(posedge clk); #1;
    addr[0] = 19'h10; w_rb[0] = 1'b0; acc[0] = 2'd0;
    #1 chk("busy_not_ready", ready[0], 0);
    chk("busy_legal_nofault", fault[0], 0);
    @(posedge clk); #1;
    acc[0] = 2'd3;
    #1 chk("busy_illegal_nofault", fault[0], 0);
    chk("strobe_we_low", we_b[0], 0);
    chk("strobe_dir_out", dir[0], 1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("strobe2_we_low", we_b[0], 0);
    rstn = 1'b0;
    #1 chk("rst_ce_high_mid", ce_b[0], 1);
    @(posedge clk); #1;
    chk("abort_we_high", we_b[0], 1);
    chk("abort_dir_in", dir[0], 0);
    chk("abort_resp_low", resp[0], 0);
    chk("abort_rdata_zero", rdata[0], 0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    @(posedge clk); #1;
    chk("abort_ready", ready[0], 1);
    rc = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (resp[0]) rc++;
    end
    chk("abort_no_resp", rc, 0);
    run_vec(tv[11]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
